nibble_serial_add_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the operand width to 4*NIBBLES bits; legal range 2..16.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL mean the requester presents an operand set.
REQ-005 in_ready  output  1  SHALL mean the controller can accept an operand set.
REQ-006 a  input  4*NIBBLES  SHALL be operand A (unsigned).
REQ-007 b  input  4*NIBBLES  SHALL be operand B (unsigned).
REQ-008 cin  input  1  SHALL be the carry-in to the least-significant nibble.
REQ-009 out_valid  output  1  SHALL mean sum, cout and ovf hold a completed result.
REQ-010 out_ready  input  1  SHALL mean the consumer takes the result.
REQ-011 sum  output  4*NIBBLES  SHALL be the result sum.
REQ-012 cout  output  1  SHALL be the final carry-out.
REQ-013 ovf  output  1  SHALL be the signed overflow: the carry into the MSB XOR the carry out of the MSB.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 States SHALL be IDLE, RUN and DONE, encoded as a 2-bit enum.
REQ-016 In IDLE, in_ready SHALL be 1; in RUN and DONE, in_ready SHALL be 0.
REQ-017 An accept is in_valid && in_ready at a clock edge; on accept, a, b and cin SHALL be latched, idx SHALL be cleared to 0, and the state SHALL go to RUN.
REQ-018 Operand inputs SHALL be ignored while not in IDLE, including when in_valid is high.
REQ-019 In RUN, each cycle SHALL add nibble idx of A, nibble idx of B and the carry register through one 4-bit adder slice, write the result into nibble idx of the sum register, load the carry register with the slice carry-out, and increment idx.
REQ-020 When idx == NIBBLES-1 in RUN, the state SHALL go to DONE and the final cout/ovf SHALL be captured on that edge.
REQ-021 Latency SHALL be exactly NIBBLES cycles: out_valid rises NIBBLES clock edges after the accept edge.
REQ-022 In DONE, out_valid SHALL be 1 and sum/cout/ovf SHALL hold stable until out_ready is sampled high.
REQ-023 On out_ready in DONE, the state SHALL go to IDLE and out_valid SHALL deassert on that edge.
REQ-024 There SHALL be no same-edge IDLE re-accept in DONE; the next accept SHALL occur no earlier than 1 cycle after the DONE exit.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 Arithmetic SHALL be modulo 2^(4*NIBBLES) with the carry reported separately; the sum SHALL equal a+b+cin exactly.

Reset
REQ-027 Asserting rst_n low SHALL, immediately and regardless of the clock, force: state IDLE, idx 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0, busy 0, in_ready 1.
REQ-028 A reset mid-RUN or mid-DONE SHALL discard the in-flight operation; no partial result SHALL ever appear with out_valid high.
REQ-029 Reset deassertion SHALL be synchronous to clk (external synchronizer); the first accept is legal on the first edge after release.

Structure
REQ-030 Package nsa_pkg SHALL hold the state enum type and the NIBBLE_W=4 constant.
REQ-031 The datapath SHALL instantiate exactly one 4-bit ripple carry adder sub-module, ripple_carry_adder (a, b, cin, sum, carry); no other adder logic is permitted.
REQ-032 idx SHALL be $clog2(NIBBLES) bits wide, and nibble select SHALL use indexed part-select.

Verification (NIBBLES=4)
REQ-033 Accept a=0x0000, b=0x0005, cin=0 -> after 4 cycles: out_valid=1, sum=0x0005, cout=0, ovf=0.
REQ-034 Accept a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-035 Accept a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1; hold out_ready=0 for 5 cycles -> result stable, in_ready=0 throughout.
REQ-036 Toggle in_valid with new operands during RUN -> ignored; the result matches the originally accepted operands.
REQ-037 Assert rst_n low 2 cycles after an accept -> outputs reset immediately; after release, accept 0x1234+0x4321 -> sum=0x5555, cout=0.
REQ-038 Apply 1000 random back-to-back transactions with random out_ready stalls -> every result matches the a+b+cin reference model and none is lost or duplicated.

Source files
------------

// File: rtl/nsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nsa_pkg
// Description : Shared types and constants for the nibble-serial adder
//               controller: FSM state encoding, nibble width and a helper
//               that recovers the carry into a slice's top bit.
// Revision    : 1.0 - initial release
// ============================================================================
package nsa_pkg;

  // Width of one adder slice (one nibble).
  localparam int NIBBLE_W = 4;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The slice adder only exposes its final carry. The carry that entered
  // the top bit is recovered from that bit's operands and sum:
  // s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
  function automatic logic msb_carry_in(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
    return a_msb ^ b_msb ^ s_msb;
  endfunction

endpackage : nsa_pkg
`default_nettype wire

// File: rtl/ripple_carry_adder.sv
`default_nettype none
// ============================================================================
// Module      : ripple_carry_adder
// Description : Combinational ripple-carry adder slice built from a chain
//               of full adders. Used as the single arithmetic resource of
//               the nibble-serial controller.
// Ports       : a, b   - addend slices (WIDTH bits)
//               cin    - carry into bit 0
//               sum    - WIDTH-bit sum
//               carry  - carry out of the top bit
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_carry_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = NIBBLE_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // w_c[i] is the carry into bit i; w_c[WIDTH] is the carry out.
  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign carry = w_c[WIDTH];

endmodule : ripple_carry_adder
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_add_ctrl
// Description : Adds two unsigned 4*NIBBLES-bit operands plus a carry-in,
//               one nibble per clock, through a single 4-bit ripple adder.
//               Valid/ready handshake on both the operand and result side.
//               A result appears NIBBLES edges after the accept edge and is
//               held until the consumer takes it.
// Ports       : clk, rst_n           - clock, async active-low reset
//               in_valid / in_ready  - operand handshake
//               a, b, cin            - operands and carry-in
//               out_valid / out_ready- result handshake
//               sum, cout, ovf       - result, carry-out, signed overflow
//               busy                 - high whenever not idle
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy
);

  localparam int c_width   = NIBBLE_W * NIBBLES;
  localparam int c_idx_w   = $clog2(NIBBLES);
  localparam int c_nib_lsb = $clog2(NIBBLE_W);
  localparam int c_base_w  = c_idx_w + c_nib_lsb;

  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NIBBLES - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t               r_state;
  state_t               w_next_state;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_width-1:0]   r_a;
  logic [c_width-1:0]   r_b;
  logic                 r_carry;
  logic [c_width-1:0]   r_sum;
  logic                 r_cout;
  logic                 r_ovf;

  // --------------------------------------------------------------------------
  // Control decodes
  // --------------------------------------------------------------------------
  logic w_accept;
  logic w_step;
  logic w_last;
  logic w_in_ready;
  logic w_out_valid;
  logic w_busy;

  // --------------------------------------------------------------------------
  // Slice datapath
  // --------------------------------------------------------------------------
  logic [c_base_w-1:0]  w_base;
  logic [NIBBLE_W-1:0]  w_a_nib;
  logic [NIBBLE_W-1:0]  w_b_nib;
  logic [NIBBLE_W-1:0]  w_slice_sum;
  logic                 w_slice_carry;
  logic                 w_slice_ovf;

  // Bit offset of the current nibble: idx * NIBBLE_W.
  assign w_base  = {r_idx, {c_nib_lsb{1'b0}}};
  assign w_a_nib = r_a[w_base +: NIBBLE_W];
  assign w_b_nib = r_b[w_base +: NIBBLE_W];

  ripple_carry_adder #(
    .WIDTH (NIBBLE_W)
  ) u_slice (
    .a     (w_a_nib),
    .b     (w_b_nib),
    .cin   (r_carry),
    .sum   (w_slice_sum),
    .carry (w_slice_carry)
  );

  // Only meaningful on the last nibble, where the slice's top bit is the
  // operand MSB.
  assign w_slice_ovf = msb_carry_in(w_a_nib[NIBBLE_W-1], w_b_nib[NIBBLE_W-1],
                                    w_slice_sum[NIBBLE_W-1]) ^ w_slice_carry;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-derived outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b1;
    w_step       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (in_valid) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        // Leaving DONE goes through IDLE, so a new accept can never share
        // the edge that retires the current result.
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_last   = (r_idx == c_last_idx);
  assign w_accept = in_valid && w_in_ready;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
      r_sum   <= '0;
    end else if (w_step) begin
      r_sum[w_base +: NIBBLE_W] <= w_slice_sum;
      r_carry                   <= w_slice_carry;
      if (w_last) begin
        // Park idx at zero so it never leaves the legal range when
        // NIBBLES is not a power of two.
        r_idx  <= '0;
        r_cout <= w_slice_carry;
        r_ovf  <= w_slice_ovf;
      end else begin
        r_idx <= r_idx + c_idx_one;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule : nibble_serial_add_ctrl
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_add_ctrl
// Description : Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4):
//               directed vector table, hand-written stall / noise / reset
//               sequences and a randomized run against an a+b+cin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;
  localparam int N_RAND  = 1000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain wide addition; signed overflow when both operands
  // share a sign that the result does not.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    res_t       r;
    logic [W:0] full;
    full   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ma[W-1] == mb[W-1]) && (r.sum[W-1] != ma[W-1]);
    return r;
  endfunction

  // One full transaction from IDLE. noise: junk on the operand port and
  // out_ready high while running, plus an in_valid at the DONE exit edge.
  task automatic run_txn(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic [W-1:0] es, input logic ec, input logic eo,
                         input bit noise, input int stall);
    int lat;
    @(negedge clk);
    check({nm, " in_ready idle"}, 64'(in_ready), 64'(1));
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, " busy/in_ready/out_valid after accept"},
          64'({busy, in_ready, out_valid}), 64'(3'b100));
    lat = 0;
    while (!out_valid && lat < 4 * NIBBLES + 4) begin
      if (noise) begin
        in_valid  = 1'($urandom_range(1));
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom_range(1));
        out_ready = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({nm, " latency"}, 64'(lat), 64'(NIBBLES));
    check({nm, " sum"},  64'(sum),  64'(es));
    check({nm, " cout"}, 64'(cout), 64'(ec));
    check({nm, " ovf"},  64'(ovf),  64'(eo));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, " stall hold"}, 64'({out_valid, in_ready, sum, cout, ovf}),
            64'({1'b1, 1'b0, es, ec, eo}));
    end
    if (noise) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({nm, " exit to idle"}, 64'({out_valid, busy, in_ready}), 64'(3'b001));
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  vec_t vecs[7];
  res_t exp_q[$];

  initial begin
    res_t e;
    int   sent, got, cyc;
    bit   acc_prev;

    vecs[0] = '{16'h0000, 16'h0005, 1'b0, 16'h0005, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #1;
    check("reset state", 64'({out_valid, busy, in_ready, cout, ovf, sum}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed table; the all-ones case also holds the result for 5 cycles.
    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
              vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b0, (i == 3) ? 5 : 0);

    // Operand port activity during RUN must not disturb the accepted set.
    run_txn("noise", 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, 1'b1, 2);

    // Reset two cycles into a run.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async reset mid-run", 64'({out_valid, busy, in_ready, cout, ovf, sum}),
          64'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}));
    repeat (3) begin
      @(negedge clk);
      check("held in reset", 64'({out_valid, busy}), 64'(2'b00));
    end
    rst_n = 1'b1;
    run_txn("post-reset", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 0);

    // Randomized back-to-back traffic with consumer stalls.
    sent = 0; got = 0; cyc = 0; acc_prev = 1'b1;
    while ((sent < N_RAND || got < sent) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!in_valid || acc_prev) begin
        in_valid = (sent < N_RAND) && ($urandom_range(3) != 0);
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom_range(1));
      end else if (!in_ready) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom_range(1));
      end
      out_ready = ($urandom_range(2) != 0);
      acc_prev  = in_valid && in_ready;
      if (acc_prev) begin
        exp_q.push_back(model(a, b, cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand unexpected result: got %0h with no transaction outstanding", sum);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rand result %0d", got), 64'({sum, cout, ovf}),
                64'({e.sum, e.cout, e.ovf}));
          got++;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand results received", 64'(got), 64'(N_RAND));
    check("rand nothing outstanding", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule : tb_nibble_serial_add_ctrl
`default_nettype wire
